alu_ext: RTL and testbench



---
 rtl/alu_ext_pkg.sv | 21 ++
 rtl/alu_ext_if.sv | 12 +
 rtl/mdu_iter.sv | 55 +++++
 rtl/alu_ext.sv | 100 ++++++++++
 tb/tb_alu_ext.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_ext_pkg.sv
// alu_ext_pkg: op encodings, FSM states and op classification helpers for alu_ext
package alu_ext_pkg;
  typedef enum logic [2:0] {IDLE, EXEC, ITER, FIX, DONE} state_t;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b001000, OP_SLL = 6'b000001;
  localparam logic [5:0] OP_SLT = 6'b000010, OP_SLTU = 6'b000011, OP_XOR = 6'b000100;
  localparam logic [5:0] OP_SRL = 6'b000101, OP_OR = 6'b000110, OP_AND = 6'b000111;
  localparam logic [5:0] OP_SRA = 6'b001101, OP_BEQ = 6'b010000, OP_BNE = 6'b010001;
  localparam logic [5:0] OP_BLT = 6'b010100, OP_BGE = 6'b010101, OP_BLTU = 6'b010110;
  localparam logic [5:0] OP_BGEU = 6'b010111;
  localparam logic [5:0] OP_MUL = 6'b100000, OP_MULH = 6'b100001, OP_MULHSU = 6'b100010;
  localparam logic [5:0] OP_MULHU = 6'b100011, OP_DIV = 6'b100100, OP_DIVU = 6'b100101;
  localparam logic [5:0] OP_REM = 6'b100110, OP_REMU = 6'b100111;
  function automatic logic is_m_op(input logic [5:0] op);
    return op[5:3] == 3'b100;
  endfunction
  function automatic logic is_valid_op(input logic [5:0] op, input logic en_m);
    return (op inside {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND,
                       OP_SRA, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU})
           || (en_m && is_m_op(op));
  endfunction
endpackage

// File: rtl/alu_ext_if.sv
// alu_ext_if: sequencer handshake bus; master drives available/op/in_a/in_b, slave returns out/busy/fault
interface alu_ext_if #(parameter int WIDTH = 32) ();
  logic available;
  logic [5:0] op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] out;
  logic busy;
  logic fault;
  modport master (output available, op, in_a, in_b, input out, busy, fault);
  modport slave (input available, op, in_a, in_b, output out, busy, fault);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: 1 bit/cycle shift-add multiply and restoring divide on magnitudes; ports clk, reset, start, op, a, b in; done, result out
module mdu_iter #(parameter int WIDTH = 32) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [2:0] op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [2:0] op_q;
  logic neg_a, neg_b, sa, sb, ge;
  logic [WIDTH-1:0] mb, hi, lo, rn, q, r;
  logic [WIDTH:0] sum, t;
  logic [2*WIDTH-1:0] p, p_step, sp;
  logic [CW-1:0] cnt;
  assign hi = p[2*WIDTH-1:WIDTH];
  assign lo = p[WIDTH-1:0];
  always_comb begin
    sa = op[2] ? !op[0] : op[1:0] != 2'b11;
    sb = op[2] ? !op[0] : !op[1];
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
    t = {hi, lo[WIDTH-1]};
    ge = t >= {1'b0, mb};
    rn = ge ? t[WIDTH-1:0] - mb : t[WIDTH-1:0];
    p_step = op_q[2] ? {rn, lo[WIDTH-2:0], ge} : {sum, lo[WIDTH-1:1]};
    sp = (neg_a ^ neg_b) ? -p : p;
    q = (neg_a ^ neg_b) ? -lo : lo;
    r = neg_a ? -hi : hi;
    result = !op_q[2] ? (op_q[1:0] == 2'b00 ? sp[WIDTH-1:0] : sp[2*WIDTH-1:WIDTH])
           : op_q[1] ? r : (mb == '0 ? '1 : q);
    done = cnt == CW'(1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_q <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      mb <= '0;
      p <= '0;
      cnt <= '0;
    end else if (start) begin
      op_q <= op;
      neg_a <= sa && a[WIDTH-1];
      neg_b <= sb && b[WIDTH-1];
      mb <= (sb && b[WIDTH-1]) ? -b : b;
      p <= {{WIDTH{1'b0}}, (sa && a[WIDTH-1]) ? -a : a};
      cnt <= CW'(WIDTH);
    end else if (cnt != '0) begin
      p <= p_step;
      cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/alu_ext.sv
// alu_ext: RV32I/E ALU plus optional iterative RV32M; ports clk, reset and an alu_ext_if slave (available/op/in_a/in_b in, out/busy/fault out)
module alu_ext #(
  parameter int WIDTH = 32,
  parameter bit ENABLE_M = 1
) (
  input logic clk,
  input logic reset,
  alu_ext_if.slave bus
);
  import alu_ext_pkg::*;
  localparam int SW = $clog2(WIDTH);
  state_t state, state_n;
  logic [5:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, out_q, out_n, base_res, m_res;
  logic fault_q, fault_n, m_start, m_done, lt, ltu;
  logic [SW-1:0] sh;
  always_comb begin
    sh = b_q[SW-1:0];
    lt = $signed(a_q) < $signed(b_q);
    ltu = a_q < b_q;
    case (op_q)
      OP_ADD:  base_res = a_q + b_q;
      OP_SUB:  base_res = a_q - b_q;
      OP_SLL:  base_res = a_q << sh;
      OP_SRL:  base_res = a_q >> sh;
      OP_SRA:  base_res = $signed(a_q) >>> sh;
      OP_XOR:  base_res = a_q ^ b_q;
      OP_OR:   base_res = a_q | b_q;
      OP_AND:  base_res = a_q & b_q;
      OP_SLT, OP_BLT:   base_res = WIDTH'(lt);
      OP_SLTU, OP_BLTU: base_res = WIDTH'(ltu);
      OP_BGE:  base_res = WIDTH'(!lt);
      OP_BGEU: base_res = WIDTH'(!ltu);
      OP_BEQ:  base_res = WIDTH'(a_q == b_q);
      OP_BNE:  base_res = WIDTH'(a_q != b_q);
      default: base_res = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    out_n = out_q;
    fault_n = fault_q;
    m_start = 1'b0;
    case (state)
      IDLE: if (bus.available) begin
        if (!is_valid_op(bus.op, ENABLE_M)) begin
          fault_n = 1'b1;
          state_n = DONE;
        end else if (is_m_op(bus.op)) begin
          m_start = 1'b1;
          state_n = ITER;
        end else state_n = EXEC;
      end
      EXEC: begin
        out_n = base_res;
        state_n = DONE;
      end
      ITER: state_n = m_done ? FIX : ITER;
      FIX: begin
        out_n = m_res;
        state_n = DONE;
      end
      DONE: if (!bus.available) begin
        fault_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      out_q <= '0;
      fault_q <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state <= state_n;
      out_q <= out_n;
      fault_q <= fault_n;
      if (state == IDLE && bus.available) begin
        op_q <= bus.op;
        a_q <= bus.in_a;
        b_q <= bus.in_b;
      end
    end
  assign bus.out = out_q;
  assign bus.fault = fault_q;
  assign bus.busy = state inside {EXEC, ITER, FIX};
  if (ENABLE_M) begin : g_m
    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
      .clk(clk), .reset(reset), .start(m_start), .op(bus.op[2:0]),
      .a(bus.in_a), .b(bus.in_b), .done(m_done), .result(m_res)
    );
  end else begin : g_nm
    assign m_done = 1'b0;
    assign m_res = '0;
  end
endmodule

// File: tb/tb_alu_ext.sv
// tb_alu_ext: scoreboard bench for alu_ext with WIDTH=32, WIDTH=16 and ENABLE_M=0 instances
module tb_alu_ext;
  import alu_ext_pkg::*;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  alu_ext_if #(32) bus();
  alu_ext_if #(16) b16();
  alu_ext_if #(32) bnm();
  alu_ext #(.WIDTH(32), .ENABLE_M(1)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  alu_ext #(.WIDTH(16), .ENABLE_M(1)) dut16 (.clk(clk), .reset(reset), .bus(b16.slave));
  alu_ext #(.WIDTH(32), .ENABLE_M(0)) dutnm (.clk(clk), .reset(reset), .bus(bnm.slave));
  typedef struct {logic [31:0] out; logic fault; int cyc;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0;
  bit mon_off = 0;
  logic busy_d = 0, fault_d = 0;
  logic [31:0] last_out = 0;
  localparam int B = 1, M = 33;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!mon_off && ((busy_d && !bus.busy) || (bus.fault && !fault_d))) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: out %h fault %b with empty scoreboard", bus.out, bus.fault);
      end else begin
        e = sb.pop_front();
        chk("out", bus.out, e.out);
        chk("fault", bus.fault, e.fault);
        chk("latency", cyc, e.cyc);
        chk("busy_at_done", bus.busy, 0);
      end
    end
    busy_d = bus.busy;
    fault_d = bus.fault;
  end
  task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_out, input logic exp_fault, input int lat);
    int n;
    logic [31:0] hold;
    @(negedge clk);
    bus.available = 1;
    bus.op = op;
    bus.in_a = a;
    bus.in_b = b;
    hold = exp_fault ? last_out : exp_out;
    sb.push_back('{hold, exp_fault, cyc + 1 + lat});
    last_out = hold;
    @(negedge clk);
    bus.op = 6'($urandom);
    bus.in_a = $urandom;
    bus.in_b = $urandom;
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL timeout: busy still %b, required 0 within 100 cycles", bus.busy);
    end
    repeat (2) @(negedge clk);
    chk("done_hold_busy", bus.busy, 0);
    chk("done_hold_out", bus.out, hold);
    chk("done_hold_fault", bus.fault, exp_fault);
    bus.available = 0;
    @(negedge clk);
    chk("idle_fault_clear", bus.fault, 0);
  endtask
  task automatic r16(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] exp, input int lat);
    @(negedge clk);
    b16.available = 1;
    b16.op = op;
    b16.in_a = a;
    b16.in_b = b;
    @(negedge clk);
    b16.in_a = ~a;
    b16.in_b = ~b;
    repeat (lat - 1) @(negedge clk);
    chk("w16_busy_before", b16.busy, 1);
    @(negedge clk);
    chk("w16_busy_after", b16.busy, 0);
    chk("w16_out", b16.out, exp);
    b16.available = 0;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.available = 0; bus.op = 0; bus.in_a = 0; bus.in_b = 0;
    b16.available = 0; b16.op = 0; b16.in_a = 0; b16.in_b = 0;
    bnm.available = 0; bnm.op = 0; bnm.in_a = 0; bnm.in_b = 0;
    repeat (2) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_out", bus.out, 0);
    chk("reset_fault", bus.fault, 0);
    reset = 0;
    run(OP_SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 0, B);
    run(OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 0, B);
    run(OP_SRA, 32'h80000000, 32'h4, 32'hF8000000, 0, B);
    run(OP_BGE, 32'hFFFFFFFF, 32'h1, 32'h0, 0, B);
    run(OP_BGEU, 32'hFFFFFFFF, 32'h1, 32'h1, 0, B);
    run(OP_SLT, 32'h80000000, 32'h0, 32'h1, 0, B);
    run(OP_SLL, 32'h1, 32'h23, 32'h8, 0, B);
    run(OP_SRL, 32'h80000000, 32'h1F, 32'h1, 0, B);
    run(OP_SLTU, 32'h1, 32'hFFFFFFFF, 32'h1, 0, B);
    run(OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, B);
    run(OP_OR, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, B);
    run(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, B);
    run(OP_BEQ, 32'h5, 32'h5, 32'h1, 0, B);
    run(OP_BNE, 32'h5, 32'h5, 32'h0, 0, B);
    run(OP_BLT, 32'hFFFFFFFF, 32'h0, 32'h1, 0, B);
    run(OP_BLTU, 32'hFFFFFFFF, 32'h0, 32'h0, 0, B);
    run(6'b011111, 32'h1, 32'h2, 32'h0, 1, 0);
    run(OP_MUL, 32'h7, 32'h6, 32'h2A, 0, M);
    run(OP_MUL, 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFD, 0, M);
    run(OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 0, M);
    run(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, M);
    run(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, M);
    run(OP_DIV, 32'h7, 32'h0, 32'hFFFFFFFF, 0, M);
    run(OP_REM, 32'h7, 32'h0, 32'h7, 0, M);
    run(OP_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 0, M);
    run(OP_REM, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 0, M);
    run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, M);
    run(OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 0, M);
    run(OP_REM, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 0, M);
    run(OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 0, M);
    run(6'b110000, 32'h1, 32'h2, 32'h0, 1, 0);
    run(OP_DIVU, 32'd100, 32'd7, 32'd14, 0, M);
    run(OP_REMU, 32'd100, 32'd7, 32'd2, 0, M);
    @(negedge clk);
    bus.available = 1;
    bus.op = OP_DIV;
    bus.in_a = 32'd1000;
    bus.in_b = 32'd3;
    repeat (6) @(negedge clk);
    chk("mid_iter_busy", bus.busy, 1);
    bus.in_a = 32'h12345678;
    mon_off = 1;
    #2 reset = 1;
    #1;
    chk("async_reset_busy", bus.busy, 0);
    chk("async_reset_out", bus.out, 0);
    chk("async_reset_fault", bus.fault, 0);
    @(negedge clk);
    reset = 0;
    bus.available = 0;
    repeat (2) @(negedge clk);
    mon_off = 0;
    last_out = 0;
    run(OP_MUL, 32'd1234, 32'd1000, 32'd1234000, 0, M);
    run(OP_ADD, 32'd40, 32'd2, 32'd42, 0, B);
    r16(OP_ADD, 16'hFFFF, 16'h0002, 16'h0001, 1);
    r16(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 17);
    r16(OP_MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
    @(negedge clk);
    bnm.available = 1; bnm.op = OP_ADD; bnm.in_a = 32'd2; bnm.in_b = 32'd3;
    repeat (2) @(negedge clk);
    chk("nm_add_out", bnm.out, 5);
    bnm.available = 0;
    repeat (2) @(negedge clk);
    bnm.available = 1; bnm.op = OP_MUL;
    @(negedge clk);
    chk("nm_m_fault", bnm.fault, 1);
    chk("nm_m_busy", bnm.busy, 0);
    chk("nm_m_out", bnm.out, 5);
    bnm.available = 0;
    @(negedge clk);
    chk("nm_fault_clear", bnm.fault, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
